// File: rtl/mux_8to1_rr_arb.sv
// Round-robin arbitrated 8:1 single-bit mux with bounded bursts per grant.
// Optional ARB_LOCK_EN adds a lock input that lets the owner extend its burst.
module mux_8to1_rr_arb #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] in,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       out,
    output logic       out_valid,
    output logic       busy
);

    // state | meaning
    // IDLE  | no owner, gnt all-zero, waiting for any req
    // GRANT | sel owns the mux, gnt = 1 << sel, beats counted
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] CNT_MAX  = 4'(BURST_MAX);
    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    state_t     state, state_n;
    logic [7:0] gnt_n;
    logic [2:0] sel_n, ptr, ptr_n, ptr_rel;
    logic [3:0] cnt, cnt_n;
    logic       out_n, ov_n;
    logic       beat, hold, release_now;
    logic [3:0] pick_idle, pick_rel;

    // Returns {found, index} of the first set bit at or above p, wrapping 7->0.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = 4'b0;
        for (int i = 0; i < 8; i++) begin
            k = p + i[2:0];
            if (r[k] && !res[3]) res = {1'b1, k};
        end
        return res;
    endfunction

`ifdef ARB_LOCK_EN
    assign hold = lock && req[sel];
`else
    assign hold = 1'b0;
`endif

    assign beat        = (state == GRANT) && req[sel];
    assign ptr_rel     = sel + 3'd1;
    assign pick_idle   = rr_pick(req, ptr);
    assign pick_rel    = rr_pick(req, ptr_rel);
    assign release_now = (state == GRANT) &&
                         (!req[sel] || (cnt >= CNT_LAST && !hold));

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        out_n   = out;
        ov_n    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[3]) begin
                    state_n = GRANT;
                    sel_n   = pick_idle[2:0];
                    gnt_n   = 8'd1 << pick_idle[2:0];
                    cnt_n   = 4'd0;
                end
            end
            GRANT: begin
                if (beat) begin
                    out_n = in[sel];
                    ov_n  = 1'b1;
                    cnt_n = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 4'd1;
                end
                // Re-arbitrate in the release cycle so the next owner follows with no bubble.
                if (release_now) begin
                    ptr_n = ptr_rel;
                    if (pick_rel[3]) begin
                        sel_n = pick_rel[2:0];
                        gnt_n = 8'd1 << pick_rel[2:0];
                        cnt_n = 4'd0;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 8'd0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            sel       <= 3'd0;
            ptr       <= 3'd0;
            cnt       <= 4'd0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            out       <= out_n;
            out_valid <= ov_n;
        end
    end

    assign busy = (state == GRANT);

endmodule
